// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative HI/LO multiply/divide unit for the EX stage.
//
// Multiplies by radix-2 shift-add and divides by restoring division, one
// bit per cycle on operand magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. MTHI/MTLO write HI/LO directly at issue.
//
// Build option: define MDU_DIV_EN to compile in the divider. Without it,
// DIV/DIVU are decoded as NOP.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  issue strobe, sampled on the rising edge
//   op     3-bit operation code (NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO/reserved)
//   op_a   rs operand
//   op_b   rt operand
//   flush  kills any in-flight operation and blocks a same-cycle issue
//   busy   operation in progress (stall request)
//   done   one-cycle completion pulse, coincident with new HI/LO
//   hi     HI register
//   lo     LO register
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [5:0] LAST_ITER = 6'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
`ifdef MDU_DIV_EN
    ST_DIV  = 2'd2,
`endif
    ST_FIX  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [5:0]              cnt_r;
  // acc_hi_r/acc_lo_r: product accumulator, or remainder/quotient for divide
  logic [DATA_WIDTH-1:0]   acc_hi_r, acc_lo_r, opnd_r;
  logic                    neg_q_r;
  logic                    busy_r, done_r;
  logic [DATA_WIDTH-1:0]   hi_r, lo_r;
  logic                    accept_s, launch_s, op_signed_s, is_mul_op_s;
  logic [DATA_WIDTH:0]     mul_sum_s;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH-1:0]   res_hi_s, res_lo_s;
`ifdef MDU_DIV_EN
  logic [DATA_WIDTH-1:0]   a_r;
  logic                    neg_r_r, dz_r, is_div_r, is_div_op_s;
  logic [DATA_WIDTH:0]     div_trial_s;
`endif

  // Magnitude of a value, treating it as two's complement only when signed.
  function automatic logic [DATA_WIDTH-1:0] mag(input logic [DATA_WIDTH-1:0] v,
                                                input logic sgn);
    if (sgn && v[DATA_WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Issue decode: an issue is only taken in IDLE and never alongside flush.
  always_comb begin
    accept_s    = start && !flush && (state_r == ST_IDLE);
    op_signed_s = (op == OP_MULT) || (op == OP_DIV);
    is_mul_op_s = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_DIV_EN
    is_div_op_s = (op == OP_DIV) || (op == OP_DIVU);
    launch_s    = accept_s && (is_mul_op_s || is_div_op_s);
`else
    launch_s    = accept_s && is_mul_op_s;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && is_mul_op_s) begin
          state_s = ST_MUL;
`ifdef MDU_DIV_EN
        end else if (accept_s && is_div_op_s) begin
          state_s = ST_DIV;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == LAST_ITER) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_MUL;
        end
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        if (flush) begin
          state_s = ST_IDLE;
        end else if (cnt_r == LAST_ITER) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_DIV;
        end
      end
`endif
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Iteration arithmetic and the sign-corrected results written in FIX.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi_r} + {1'b0, opnd_r};
    prod_s    = neg_q_r ? -{acc_hi_r, acc_lo_r} : {acc_hi_r, acc_lo_r};
`ifdef MDU_DIV_EN
    // Trial subtract of the divisor from the remainder shifted left by one.
    div_trial_s = {acc_hi_r, acc_lo_r[DATA_WIDTH-1]} - {1'b0, opnd_r};
    if (is_div_r && dz_r) begin
      res_hi_s = a_r;
      res_lo_s = {DATA_WIDTH{1'b1}};
    end else if (is_div_r) begin
      res_hi_s = neg_r_r ? -acc_hi_r : acc_hi_r;
      res_lo_s = neg_q_r ? -acc_lo_r : acc_lo_r;
    end else begin
      res_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
      res_lo_s = prod_s[DATA_WIDTH-1:0];
    end
`else
    res_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
    res_lo_s = prod_s[DATA_WIDTH-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 6'd0;
      acc_hi_r <= {DATA_WIDTH{1'b0}};
      acc_lo_r <= {DATA_WIDTH{1'b0}};
      opnd_r   <= {DATA_WIDTH{1'b0}};
      neg_q_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {DATA_WIDTH{1'b0}};
      lo_r     <= {DATA_WIDTH{1'b0}};
`ifdef MDU_DIV_EN
      a_r      <= {DATA_WIDTH{1'b0}};
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      is_div_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 6'd0;
          if (launch_s) begin
            acc_hi_r <= {DATA_WIDTH{1'b0}};
            neg_q_r  <= op_signed_s & (op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1]);
            // Multiply shifts the multiplier (op_b) out of acc_lo; divide
            // shifts the dividend (op_a) out and the quotient in.
            if (is_mul_op_s) begin
              acc_lo_r <= mag(op_b, op_signed_s);
              opnd_r   <= mag(op_a, op_signed_s);
            end else begin
              acc_lo_r <= mag(op_a, op_signed_s);
              opnd_r   <= mag(op_b, op_signed_s);
            end
`ifdef MDU_DIV_EN
            a_r      <= op_a;
            neg_r_r  <= op_signed_s & op_a[DATA_WIDTH-1];
            dz_r     <= (op_b == {DATA_WIDTH{1'b0}});
            is_div_r <= is_div_op_s;
`endif
          end
          if (accept_s && (op == OP_MTHI)) begin
            hi_r <= op_a;
          end
          if (accept_s && (op == OP_MTLO)) begin
            lo_r <= op_a;
          end
        end
        ST_MUL: begin
          if (flush) begin
            cnt_r <= 6'd0;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
          if (acc_lo_r[0]) begin
            {acc_hi_r, acc_lo_r} <= {mul_sum_s, acc_lo_r[DATA_WIDTH-1:1]};
          end else begin
            {acc_hi_r, acc_lo_r} <= {1'b0, acc_hi_r, acc_lo_r[DATA_WIDTH-1:1]};
          end
        end
`ifdef MDU_DIV_EN
        ST_DIV: begin
          if (flush) begin
            cnt_r <= 6'd0;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
          if (!div_trial_s[DATA_WIDTH]) begin
            acc_hi_r <= div_trial_s[DATA_WIDTH-1:0];
            acc_lo_r <= {acc_lo_r[DATA_WIDTH-2:0], 1'b1};
          end else begin
            acc_hi_r <= {acc_hi_r[DATA_WIDTH-2:0], acc_lo_r[DATA_WIDTH-1]};
            acc_lo_r <= {acc_lo_r[DATA_WIDTH-2:0], 1'b0};
          end
        end
`endif
        ST_FIX: begin
          cnt_r <= 6'd0;
          if (!flush) begin
            hi_r   <= res_hi_s;
            lo_r   <= res_lo_s;
            done_r <= 1'b1;
          end
        end
        default: cnt_r <= 6'd0;
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, flush/reset
// corner cases and randomized operations against an arithmetic model.
module tb_mult_div_unit;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;
  localparam logic [2:0] OP_RSV   = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: architectural HI/LO effect of one accepted operation.
  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic long_op);
    longint      p;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    long_op = 1'b0;
    case (o)
      OP_MULT: begin
        p = longint'(sa) * longint'(sb);
        {m_hi, m_lo} = p;
        long_op = 1'b1;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = up;
        long_op = 1'b1;
      end
      OP_DIV: begin
`ifdef MDU_DIV_EN
        long_op = 1'b1;
        if (b == 32'd0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          m_lo = 32'h80000000; m_hi = 32'd0;
        end else begin
          m_lo = sa / sb; m_hi = sa % sb;
        end
`endif
      end
      OP_DIVU: begin
`ifdef MDU_DIV_EN
        long_op = 1'b1;
        if (b == 32'd0) begin
          m_lo = 32'hFFFFFFFF; m_hi = a;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
`endif
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one operation and check its whole timeline against the model.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic long_op;
    int   cyc;
    logic seen_done;
    model_op(o, a, b, long_op);
    @(negedge clk);
    start = 1'b1; flush = 1'b0; op = o; op_a = a; op_b = b;
    @(posedge clk); #1;
    if (long_op) begin
      check_eq("busy_after_start", busy, 1'b1);
      cyc = 1;
      seen_done = 1'b0;
      while (busy && cyc < 100) begin
        @(negedge clk);
        // scramble inputs; one stray issue while busy must be ignored
        start = (cyc == 5);
        op = OP_MULT;
        op_a = $urandom;
        op_b = $urandom;
        @(posedge clk); #1;
        if (busy) begin
          cyc++;
          seen_done = seen_done | done;
        end
      end
      check_eq("busy_cycles", cyc, 33);
      check_eq("done_early", seen_done, 1'b0);
      check_eq("done_pulse", done, 1'b1);
      check_eq("hi_result", hi, m_hi);
      check_eq("lo_result", lo, m_lo);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      check_eq("done_width", done, 1'b0);
    end else begin
      check_eq("short_busy", busy, 1'b0);
      check_eq("short_done", done, 1'b0);
      check_eq("short_hi", hi, m_hi);
      check_eq("short_lo", lo, m_lo);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick_val();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h80000000;
      2:       v = 32'hFFFFFFFF;
      3:       v = $urandom_range(0, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = OP_NOP; op_a = 32'd0; op_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    do_op(OP_MULT, 32'hFFFFFFFE, 32'h00000003);
    check_eq("mult_neg2x3_hi", hi, 32'hFFFFFFFF);
    check_eq("mult_neg2x3_lo", lo, 32'hFFFFFFFA);
    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_eq("multu_max_hi", hi, 32'hFFFFFFFE);
    check_eq("multu_max_lo", lo, 32'h00000001);
    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    do_op(OP_DIVU, 32'd7, 32'd0);
    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    do_op(OP_DIV, 32'hFFFFFFF0, 32'd0);
    do_op(OP_DIVU, 32'd9, 32'd3);
    do_op(OP_NOP, 32'h11111111, 32'h22222222);
    do_op(OP_RSV, 32'h33333333, 32'h44444444);

    // Flush mid-multiply, then immediate re-issue
    do_op(OP_MTHI, 32'h12345678, 32'd0);
    @(negedge clk);
    start = 1'b1; op = OP_MULT; op_a = $urandom; op_b = $urandom;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    check_eq("flush_busy", busy, 1'b0);
    check_eq("flush_done", done, 1'b0);
    check_eq("flush_hi", hi, 32'h12345678);
    check_eq("flush_lo", lo, m_lo);
    do_op(OP_MULT, 32'd5, 32'hFFFFFFFD);

    // Flush during the FIX cycle
    @(negedge clk);
    start = 1'b1; op = OP_MULTU; op_a = 32'hABCDEF01; op_b = 32'h10203040;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (32) @(posedge clk);
    @(negedge clk);
    check_eq("busy_in_fix", busy, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    check_eq("fixflush_busy", busy, 1'b0);
    check_eq("fixflush_done", done, 1'b0);
    check_eq("fixflush_hi", hi, m_hi);
    check_eq("fixflush_lo", lo, m_lo);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    check_eq("fixflush_done2", done, 1'b0);

    // Start coincident with flush is ignored
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_MTLO; op_a = 32'h5A5A5A5A;
    @(posedge clk); #1;
    check_eq("sflush_lo", lo, m_lo);
    @(negedge clk);
    op = OP_MULT; op_a = 32'd3; op_b = 32'd4;
    @(posedge clk); #1;
    check_eq("sflush_busy", busy, 1'b0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-operation
    do_op(OP_MTHI, 32'hDEADBEEF, 32'd0);
    do_op(OP_MTLO, 32'hCAFEF00D, 32'd0);
    @(negedge clk);
`ifdef MDU_DIV_EN
    start = 1'b1; op = OP_DIV; op_a = $urandom; op_b = 32'd7;
`else
    start = 1'b1; op = OP_MULT; op_a = $urandom; op_b = 32'd7;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_done", done, 1'b0);
    check_eq("arst_hi", hi, 32'd0);
    check_eq("arst_lo", lo, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      do_op(3'($urandom_range(0, 7)), pick_val(), pick_val());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand/HI/LO width; all widths and latencies below are quoted for the default.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  issue strobe from EX stage; sampled on rising edge.
REQ-006 op  in  3  000 NOP, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (NOP).
REQ-007 op_a  in  32  rs operand, taken from the forwarding-mux output.
REQ-008 op_b  in  32  rt operand, taken from the forwarding-mux output.
REQ-009 flush  in  1  kills any in-flight operation.
REQ-010 busy  out  1  operation in progress; pipeline stall request.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 hi  out  32  HI register, registered output.
REQ-013 lo  out  32  LO register, registered output.

Function
REQ-014 The FSM SHALL have four states: IDLE, MUL, DIV and FIX.
REQ-015 Operands and op SHALL be latched at the start edge; later input changes SHALL have no effect on the running operation.
REQ-016 IDLE + start + MULT/MULTU SHALL go to MUL; IDLE + start + DIV/DIVU SHALL go to DIV; busy SHALL assert in the cycle after the start edge.
REQ-017 MUL SHALL be radix-2 shift-add and DIV SHALL be restoring, each one bit per cycle, on operand magnitudes with a 6-bit iteration counter.
REQ-018 After exactly 32 iteration edges, the FSM SHALL move to FIX.
REQ-019 FIX (one cycle) SHALL apply sign correction, write hi/lo, return to IDLE, and drop busy.
REQ-020 done SHALL be 1 for exactly the one cycle after the FIX edge.
REQ-021 Latency: busy SHALL be high for exactly 33 cycles, and new hi/lo SHALL be visible together with done.
REQ-022 MULT/MULTU SHALL produce {hi,lo} = 64-bit signed/unsigned product.
REQ-023 DIV/DIVU SHALL produce lo = quotient truncated toward zero and hi = remainder, with the remainder taking the sign of the dividend.
REQ-024 Divide by zero (either signedness) SHALL give lo = 0xFFFFFFFF and hi = op_a, with unchanged latency.
REQ-025 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL give lo = 0x80000000 and hi = 0.
REQ-026 MTHI/MTLO SHALL write op_a into hi/lo at the start edge, with no busy and no done.
REQ-027 NOP and reserved op codes SHALL cause no state change.
REQ-028 start while busy SHALL be ignored.
REQ-029 flush while busy SHALL return the FSM to IDLE at the next edge, leave hi/lo unchanged, and produce no done.
REQ-030 flush in the FIX cycle SHALL suppress the hi/lo write and done.
REQ-031 start coincident with flush SHALL be ignored, including MTHI/MTLO.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, including mid-operation.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-034 With macro MDU_DIV_EN defined, the divider datapath and DIV state SHALL be compiled in and DIV/DIVU SHALL behave as above.
REQ-035 With MDU_DIV_EN undefined, the divider SHALL be absent and DIV/DIVU SHALL be treated as NOP: busy stays 0, no done, hi/lo unchanged; MULT/MTHI/MTLO SHALL be unaffected.

Verification
REQ-036 MULT op_a=0xFFFFFFFE (-2), op_b=0x00000003 -> busy 33 cycles, then done pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-037 MULTU op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at done.
REQ-038 DIV op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
REQ-039 MTHI 0x12345678, then MULT started with flush asserted at iteration 10 -> hi remains 0x12345678, no done; start on the following edge is accepted.
REQ-040 rst_n pulsed low at iteration 20 of a DIV -> busy, hi and lo read 0 immediately; with MDU_DIV_EN undefined, DIVU 9/3 -> busy never asserts and hi/lo are unchanged.
